// File: rtl/multi_lane_gate_ctrl_pkg.sv
// Shared types and constants for the multi-lane parking exit controller.
package gate_pkg;

    localparam int TAL_W = 2;

    // Barrier state; the encoding is visible on the TAL output.
    typedef enum logic [TAL_W-1:0] {
        DOWN       = 2'b00,
        UP_START   = 2'b01,
        UP         = 2'b10,
        DOWN_START = 2'b11
    } tal_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PAY   = 2'b01,
        VALID = 2'b10
    } pay_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/multi_lane_gate_ctrl_if.sv
// Per-lane ticket/coin/sensor inputs and status outputs, packed lane-major.
interface multi_lane_gate_ctrl_if
    import gate_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int DW        = 3
) ();

    logic [NUM_LANES-1:0]       iT;
    logic [NUM_LANES-1:0]       iM;
    logic [NUM_LANES*2-1:0]     iM_val;
    logic [NUM_LANES-1:0]       C;
    logic [NUM_LANES-1:0]       T;
    logic [NUM_LANES-1:0]       V;
    logic [NUM_LANES*DW-1:0]    D;
    logic [NUM_LANES*TAL_W-1:0] TAL;
    logic                       full;

    modport master (
        output iT, iM, iM_val, C,
        input  T, V, D, TAL, full
    );

    modport slave (
        input  iT, iM, iM_val, C,
        output T, V, D, TAL, full
    );

endinterface

// File: rtl/multi_lane_gate_ctrl_lane.sv
// One exit lane: Moore payment FSM plus barrier FSM with motor-travel,
// pass-timeout and safety-reversal timing.
module gate_lane
    import gate_pkg::*;
#(
    parameter int FEE       = 3,
    parameter int DW        = 3,
    parameter int COIN_MAX  = 2,
    parameter int MOTOR_CYC = 8,
    parameter int PASS_TO   = 64
) (
    input  logic             clk,
    input  logic             R,
    input  logic             blk,
    input  logic             iT,
    input  logic             iM,
    input  logic [1:0]       iM_val,
    input  logic             C,
    output logic             T,
    output logic             V,
    output logic [DW-1:0]    D,
    output logic [TAL_W-1:0] TAL,
    output logic             pass
);

    localparam int AW = DW + 1;
    localparam int TW = $clog2(max_int(MOTOR_CYC, PASS_TO) + 1);
    localparam logic [TW-1:0] MOTOR_LD = TW'(MOTOR_CYC - 1);
    localparam logic [TW-1:0] PASS_LD  = TW'(PASS_TO - 1);
    localparam logic [AW-1:0] FEE_V    = AW'(FEE);

    pay_state_t pay_q, pay_d;
    logic [AW-1:0] acc_q, acc_nxt;
    logic [AW:0]   sum_ext;
    logic [1:0]    coin;
    logic          coin_ok;
    logic          validate;

    tal_state_t tal_q, tal_d;
    logic [TW-1:0] timer_q;
    logic          seen_q;
    logic          pend_q;
    logic          open_req;

    // Coin clamp to COIN_MAX and saturating accumulation
    always_comb begin
        coin    = (int'(iM_val) > COIN_MAX) ? 2'(COIN_MAX) : iM_val;
        coin_ok = iM && (coin != 2'd0);
        sum_ext = {1'b0, acc_q} + {{(AW-1){1'b0}}, coin};
        acc_nxt = sum_ext[AW] ? '1 : sum_ext[AW-1:0];
    end

    // Payment state register
    always_ff @(posedge clk) begin
        if (R) pay_q <= IDLE;
        else   pay_q <= pay_d;
    end

    // Payment next state; new tickets are refused while the lot is full
    always_comb begin
        pay_d = pay_q;
        case (pay_q)
            IDLE:    if (iT && !blk) pay_d = PAY;
            PAY:     if (coin_ok && acc_nxt >= FEE_V) pay_d = VALID;
            VALID:   pay_d = IDLE;
            default: pay_d = IDLE;
        endcase
    end

    // Coin accumulator, cleared while idle
    always_ff @(posedge clk) begin
        if (R) begin
            acc_q <= '0;
        end else begin
            case (pay_q)
                IDLE:    acc_q <= '0;
                PAY:     if (coin_ok) acc_q <= acc_nxt;
                default: acc_q <= acc_q;
            endcase
        end
    end

    // Payment outputs; validate fires on the edge that enters VALID
    always_comb begin
        T        = (pay_q == PAY);
        V        = (pay_q == VALID);
        D        = V ? DW'(acc_q - FEE_V) : '0;
        validate = (pay_q == PAY) && (pay_d == VALID);
    end

    // Barrier state, timer, car-seen flag and one-deep pending open
    always_ff @(posedge clk) begin
        if (R) begin
            tal_q   <= DOWN;
            timer_q <= '0;
            seen_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            tal_q <= tal_d;
            if (tal_d != tal_q)
                timer_q <= (tal_d == UP) ? PASS_LD : MOTOR_LD;
            else if (timer_q != '0)
                timer_q <= timer_q - 1'b1;
            seen_q <= (tal_q == UP && tal_d == UP) ? (seen_q | C) : 1'b0;
            // In DOWN any request is consumed by the move to UP_START
            if (tal_q == DOWN) pend_q <= 1'b0;
            else if (validate) pend_q <= 1'b1;
        end
    end

    // Barrier next state; open is Mealy on the validate edge
    always_comb begin
        tal_d    = tal_q;
        pass     = 1'b0;
        open_req = validate || pend_q;
        case (tal_q)
            DOWN:     if (open_req) tal_d = UP_START;
            UP_START: if (timer_q == '0) tal_d = UP;
            UP: begin
                if (C) begin
                    tal_d = UP;
                end else if (seen_q) begin
                    tal_d = DOWN_START;
                    pass  = 1'b1;
                end else if (timer_q == '0) begin
                    tal_d = DOWN_START;
                end
            end
            DOWN_START: begin
                if (C)                  tal_d = UP_START;
                else if (timer_q == '0) tal_d = DOWN;
            end
            default: tal_d = DOWN;
        endcase
    end

    // Barrier output
    always_comb begin
        TAL = tal_q;
    end

endmodule

// File: rtl/multi_lane_gate_ctrl.sv
// N-lane parking exit controller top: lane array plus optional shared
// occupancy counter, enabled by defining GATE_OCCUPANCY_EN.
module multi_lane_gate_ctrl
    import gate_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int FEE       = 3,
    parameter int DW        = 3,
    parameter int COIN_MAX  = 2,
    parameter int MOTOR_CYC = 8,
    parameter int PASS_TO   = 64,
    parameter int CAPACITY  = 15
) (
    input  logic                  clk,
    input  logic                  R,
    multi_lane_gate_ctrl_if.slave bus
);

    logic [NUM_LANES-1:0] pass;
    logic                 full_w;
    logic                 unused_cfg;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        gate_lane #(
            .FEE       (FEE),
            .DW        (DW),
            .COIN_MAX  (COIN_MAX),
            .MOTOR_CYC (MOTOR_CYC),
            .PASS_TO   (PASS_TO)
        ) u_lane (
            .clk    (clk),
            .R      (R),
            .blk    (full_w),
            .iT     (bus.iT[k]),
            .iM     (bus.iM[k]),
            .iM_val (bus.iM_val[2*k +: 2]),
            .C      (bus.C[k]),
            .T      (bus.T[k]),
            .V      (bus.V[k]),
            .D      (bus.D[k*DW +: DW]),
            .TAL    (bus.TAL[k*TAL_W +: TAL_W]),
            .pass   (pass[k])
        );
    end

    assign unused_cfg = ^{pass, 32'(CAPACITY)};

`ifdef GATE_OCCUPANCY_EN
    localparam int OW = $clog2(CAPACITY + 1);

    logic [OW-1:0] occ_q, occ_d;
    int unsigned   pass_cnt;
    int unsigned   occ_sum;

    // Add all same-cycle passes, saturating at CAPACITY
    always_comb begin
        pass_cnt = 0;
        for (int unsigned i = 0; i < NUM_LANES; i++)
            pass_cnt = pass_cnt + 32'(pass[i]);
        occ_sum = 32'(occ_q) + pass_cnt;
        occ_d   = (occ_sum >= 32'(CAPACITY)) ? OW'(CAPACITY) : OW'(occ_sum);
    end

    // Occupancy register
    always_ff @(posedge clk) begin
        if (R) occ_q <= '0;
        else   occ_q <= occ_d;
    end

    assign full_w = (occ_q == OW'(CAPACITY));
`else
    assign full_w = 1'b0;
`endif

    assign bus.full = full_w;

endmodule

// File: tb/tb_multi_lane_gate_ctrl.sv
// Scoreboard bench for multi_lane_gate_ctrl: directed barrier timing plus
// randomized two-lane payments checked against a transaction-level model.
module tb_multi_lane_gate_ctrl;

    localparam int NL       = 2;
    localparam int FEE      = 3;
    localparam int DW       = 3;
    localparam int COIN_MAX = 2;
    localparam int MOTOR    = 8;
    localparam int PASS     = 64;
    localparam int CAP      = 2;
`ifdef GATE_OCCUPANCY_EN
    localparam int EXP_FULL = 1;
`else
    localparam int EXP_FULL = 0;
`endif

    typedef struct {
        logic       it;
        logic       m;
        logic [1:0] v;
    } slot_t;

    logic clk = 1'b0;
    logic R   = 1'b1;
    always #5 clk = ~clk;

    multi_lane_gate_ctrl_if #(.NUM_LANES(NL), .DW(DW)) gif ();

    multi_lane_gate_ctrl #(
        .NUM_LANES (NL),
        .FEE       (FEE),
        .DW        (DW),
        .COIN_MAX  (COIN_MAX),
        .MOTOR_CYC (MOTOR),
        .PASS_TO   (PASS),
        .CAPACITY  (CAP)
    ) dut (
        .clk (clk),
        .R   (R),
        .bus (gif)
    );

    int total = 0;
    int bad   = 0;

    int         exp_q   [NL][$];
    logic [1:0] cur_st  [NL];
    logic [1:0] last_st [NL];
    int         run_len [NL];
    int         last_run[NL];
    logic       prev_v  [NL];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int tal(input int k);
        return int'(gif.TAL[2*k +: 2]);
    endfunction

    // Monitor: TAL run lengths and scoreboard pops on every V pulse
    initial begin
        for (int k = 0; k < NL; k++) begin
            cur_st[k] = 2'b00; last_st[k] = 2'b00;
            run_len[k] = 0; last_run[k] = 0; prev_v[k] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < NL; k++) begin
                if (gif.TAL[2*k +: 2] == cur_st[k]) begin
                    run_len[k]++;
                end else begin
                    last_st[k]  = cur_st[k];
                    last_run[k] = run_len[k];
                    cur_st[k]   = gif.TAL[2*k +: 2];
                    run_len[k]  = 1;
                end
                if (!R) begin
                    if (gif.V[k]) begin
                        total++;
                        if (exp_q[k].size() == 0) begin
                            bad++;
                            $display("FAIL v_unexpected lane=%0d: got V with D=%0d expected no V",
                                     k, gif.D[k*DW +: DW]);
                        end else begin
                            int e;
                            e = exp_q[k].pop_front();
                            total--;
                            chk($sformatf("change_lane%0d", k), int'(gif.D[k*DW +: DW]), e);
                        end
                        chk($sformatf("v_shape_lane%0d", k), int'(prev_v[k] | gif.T[k]), 0);
                    end else if (gif.D[k*DW +: DW] != '0) begin
                        chk($sformatf("d_idle_lane%0d", k), int'(gif.D[k*DW +: DW]), 0);
                    end
                end
                prev_v[k] = gif.V[k];
            end
        end
    end

    task automatic wait_tal(input int k, input int want, input int limit, input string name);
        int n;
        n = 0;
        while (1) begin
            @(negedge clk);
            #1;
            n++;
            if (tal(k) == want || n >= limit) break;
        end
        chk(name, tal(k), want);
    endtask

    task automatic pay(input int k, input int n, input int a, input int b);
        int v[2];
        int sum;
        v[0] = a; v[1] = b;
        sum = 0;
        for (int i = 0; i < n; i++) sum += v[i];
        exp_q[k].push_back(sum - FEE);
        @(posedge clk); #1 gif.iT[k] = 1'b1;
        @(posedge clk); #1 gif.iT[k] = 1'b0;
        for (int i = 0; i < n; i++) begin
            gif.iM[k] = 1'b1;
            gif.iM_val[2*k +: 2] = 2'(v[i]);
            @(posedge clk); #1;
        end
        gif.iM[k] = 1'b0;
        gif.iM_val[2*k +: 2] = 2'b00;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic pay3(input int k, input int a, input int b, input int c);
        exp_q[k].push_back(a + b + c - FEE);
        @(posedge clk); #1 gif.iT[k] = 1'b1;
        @(posedge clk); #1 gif.iT[k] = 1'b0;
        gif.iM[k] = 1'b1;
        gif.iM_val[2*k +: 2] = 2'(a); @(posedge clk); #1;
        gif.iM_val[2*k +: 2] = 2'(b); @(posedge clk); #1;
        gif.iM_val[2*k +: 2] = 2'(c); @(posedge clk); #1;
        gif.iM[k] = 1'b0;
        gif.iM_val[2*k +: 2] = 2'b00;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 R = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_T", int'(gif.T), 0);
        chk("rst_V", int'(gif.V), 0);
        chk("rst_D", int'(gif.D), 0);
        chk("rst_TAL", int'(gif.TAL), 0);
        chk("rst_full", int'(gif.full), 0);
        @(posedge clk); #1 R = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        slot_t plan[NL][$];
        slot_t s;
        int    sum, c, len;

        gif.iT = '0; gif.iM = '0; gif.iM_val = '0; gif.C = '0;

        // Power-on reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("por_outputs", int'({gif.T, gif.V, gif.D, gif.TAL, gif.full}), 0);
        @(posedge clk); #1 R = 1'b0;

        // Exact fee on lane 0, barrier opens for MOTOR cycles
        pay3(0, 1, 1, 1);
        wait_tal(0, 2, 20, "l0_reach_up");
        chk("l0_upstart_len", last_run[0], MOTOR);
        chk("l0_upstart_prev", int'(last_st[0]), 1);

        // Car passes under barrier, then closing travel
        @(posedge clk); #1 gif.C[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1 gif.C[0] = 1'b0;
        wait_tal(0, 3, 5, "l0_pass_close");
        wait_tal(0, 0, 20, "l0_down");
        chk("l0_downstart_len", last_run[0], MOTOR);

        // Overpay on lane 1, pass timeout, safety reversal, then a pass
        pay(1, 2, 2, 2);
        wait_tal(1, 2, 20, "l1_reach_up");
        wait_tal(1, 3, PASS + 10, "l1_timeout");
        chk("l1_up_len", last_run[1], PASS);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 gif.C[1] = 1'b1;
        @(posedge clk); #1 gif.C[1] = 1'b0;
        wait_tal(1, 1, 3, "l1_reversal");
        chk("l1_downstart_before_rev", last_run[1], 4);
        wait_tal(1, 2, 20, "l1_reup");
        chk("l1_rev_upstart_len", last_run[1], MOTOR);
        @(posedge clk); #1 gif.C[1] = 1'b1;
        @(posedge clk); #1 gif.C[1] = 1'b0;
        wait_tal(1, 3, 5, "l1_pass_close");
        wait_tal(1, 0, 20, "l1_down");
        chk("full_after_two_passes", int'(gif.full), EXP_FULL);

`ifdef GATE_OCCUPANCY_EN
        // Ticket refused while lot is full
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1 gif.iT[0] = 1'b1;
            @(negedge clk);
            chk("full_blocks_T", int'(gif.T[0]), 0);
        end
        @(posedge clk); #1 gif.iT[0] = 1'b0;
`endif

        do_reset();

        // Two payments while UP: one pending reopen, the second absorbed
        pay3(0, 1, 1, 1);
        wait_tal(0, 2, 20, "pend_up");
        pay(0, 2, 2, 1);
        pay(0, 2, 1, 2);
        wait_tal(0, 3, PASS + 10, "pend_timeout");
        wait_tal(0, 0, 20, "pend_down");
        @(negedge clk);
        chk("pend_reopen", tal(0), 1);
        wait_tal(0, 2, 20, "pend_up2");
        wait_tal(0, 3, PASS + 10, "pend_timeout2");
        wait_tal(0, 0, 20, "pend_down2");
        repeat (10) @(negedge clk);
        chk("pend_absorbed", tal(0), 0);

        // Reset while the barrier is UP
        pay(0, 2, 2, 2);
        wait_tal(0, 2, 20, "rst_mid_reach_up");
        @(posedge clk); #1 R = 1'b1;
        @(posedge clk); #1 R = 1'b0;
        @(negedge clk);
        chk("rst_mid_up_tal", tal(0), 0);

        // Randomized concurrent payments on both lanes
        for (int t = 0; t < 20; t++) begin
            for (int k = 0; k < NL; k++) begin
                plan[k].delete();
                s.it = 1'b0; s.m = 1'b0; s.v = 2'b00;
                repeat ($urandom_range(0, 3)) plan[k].push_back(s);
                s.it = 1'b1; s.m = 1'b0; s.v = 2'($urandom_range(0, 3));
                plan[k].push_back(s);
                sum = 0;
                while (sum < FEE) begin
                    s.it = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 3) == 0) begin
                        s.m = 1'b0;
                        s.v = 2'($urandom_range(0, 3));
                    end else begin
                        c = $urandom_range(0, COIN_MAX);
                        s.m = 1'b1;
                        s.v = 2'(c);
                        sum += c;
                    end
                    plan[k].push_back(s);
                end
                s.it = 1'b0; s.m = 1'b0; s.v = 2'b00;
                plan[k].push_back(s);
                plan[k].push_back(s);
                exp_q[k].push_back(sum - FEE);
            end
            len = (plan[0].size() > plan[1].size()) ? plan[0].size() : plan[1].size();
            for (int i = 0; i < len; i++) begin
                @(posedge clk); #1;
                for (int k = 0; k < NL; k++) begin
                    if (i < plan[k].size()) s = plan[k][i];
                    else begin s.it = 1'b0; s.m = 1'b0; s.v = 2'b00; end
                    gif.iT[k] = s.it;
                    gif.iM[k] = s.m;
                    gif.iM_val[2*k +: 2] = s.v;
                end
            end
            @(posedge clk); #1;
            gif.iT = '0; gif.iM = '0; gif.iM_val = '0;
        end

        repeat (5) @(negedge clk);
        for (int k = 0; k < NL; k++)
            chk($sformatf("sb_drain_lane%0d", k), exp_q[k].size(), 0);
        chk("full_end", int'(gif.full), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
